// File: rtl/enc16x4_rr_if.sv
// Request/grant bus between the 16-to-4 round-robin encoder and its
// requesters/consumer. The slave side is the encoder itself.
interface enc16x4_rr_if;
   logic [15:0] req;
   logic        ready;
   logic [3:0]  code;
   logic        valid;
   logic [15:0] onehot;
   logic [15:0] pend;

   // Requester/consumer side: raises requests and acknowledges grants
   modport master (
      output req,
      output ready,
      input  code,
      input  valid,
      input  onehot,
      input  pend
   );

   // Encoder side: captures requests and issues one grant at a time
   modport slave (
      input  req,
      input  ready,
      output code,
      output valid,
      output onehot,
      output pend
   );
endinterface

// File: rtl/enc16x4_rr.sv
// Sequential 16-to-4 round-robin encoder. Requests collect in a sticky
// pending register; one pending index at a time is issued as a 4-bit code
// (plus its one-hot image) over a valid/ready handshake. After each grant
// the search pointer moves just past the granted index for fairness.
module enc16x4_rr (
   input  logic              clk,
   input  logic              rst,
   enc16x4_rr_if.slave       bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [15:0] r_pend;
   logic [3:0]  r_code;
   logic        r_valid;
   logic [15:0] r_onehot;
   logic [3:0]  r_ptr;

   logic [3:0]  w_winner;
   logic        w_found;
   logic        w_loadGrant;
   logic        w_completeGrant;
   logic [15:0] w_clr;

   // Find the first pending bit searching from r_ptr upward with wrap;
   // walking the offsets downward lets the smallest offset win last.
   always_comb begin
      w_winner = '0;
      w_found  = |r_pend;
      for (int k = 15; k >= 0; k--) begin
         if (r_pend[r_ptr + 4'(k)]) begin
            w_winner = r_ptr + 4'(k);
         end
      end
   end

   // The granted bit is cleared only when the handshake completes
   always_comb begin
      w_clr = '0;
      if (w_completeGrant) begin
         w_clr = 16'h0001 << r_code;
      end
   end

   // Next-state logic: IDLE launches a grant when anything is pending,
   // GRANT holds its outputs until the consumer takes the code
   always_comb begin
      w_nextState     = r_state;
      w_loadGrant     = 1'b0;
      w_completeGrant = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_loadGrant = 1'b1;
               w_nextState = GRANT;
            end
         end
         GRANT: begin
            if (r_valid && bus.ready) begin
               w_completeGrant = 1'b1;
               w_nextState     = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // State, pending register and registered grant outputs; a request that
   // lands on the same edge its bit is cleared keeps the bit pending
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_pend   <= '0;
         r_code   <= '0;
         r_valid  <= 1'b0;
         r_onehot <= '0;
         r_ptr    <= '0;
      end else begin
         r_state <= w_nextState;
         r_pend  <= (r_pend & ~w_clr) | bus.req;
         if (w_loadGrant) begin
            r_code   <= w_winner;
            r_onehot <= 16'h0001 << w_winner;
            r_valid  <= 1'b1;
         end
         if (w_completeGrant) begin
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_ptr    <= r_code + 4'd1;
         end
      end
   end

   assign bus.code   = r_code;
   assign bus.valid  = r_valid;
   assign bus.onehot = r_onehot;
   assign bus.pend   = r_pend;

endmodule
